alu_rr_scheduler: RTL and testbench
===================================

// Module: alu_rr_scheduler
// PURPOSE
//   Shares one combinational ALU datapath (add/sub/mul on alu_control) between four requesters.
//   Round-robin arbitration, operand capture/hold, multicycle wait for multiply, result return tagged with requester id.
//   Sits between client blocks and the ALU; the ALU itself stays external.
// PARAMETERS
//   W           8   operand/result width; results truncated to W bits
//   MUL_CYCLES  3   EXEC cycles for multiply (>=1); add/sub always take 1
// PORTS
//   clk          in   1     rising-edge clock
//   reset_n      in   1     asynchronous active-low reset
//   req          in   4     request per requester, held until gnt sampled
//   op           in   8     op[2i+1:2i] for requester i: 0 add, 1 sub, 2 mul, 3 invalid
//   a_in         in   4*W   a_in[W*i+:W] operand x of requester i
//   b_in         in   4*W   b_in[W*i+:W] operand z of requester i
//   gnt          out  4     one-hot grant, 1-cycle pulse
//   alu_control  out  2     op driven to ALU
//   alu_x        out  W     ALU operand x
//   alu_z        out  W     ALU operand z
//   alu_y        in   W     ALU result
//   res_valid    out  1     1-cycle result strobe
//   res_data     out  W     result, valid with res_valid
//   res_id       out  2     requester index of result
//   res_err      out  1     op was 3; res_data=0
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, rr pointer=0, all outputs 0; in-flight op discarded, no res_valid.
//   - FSM IDLE -> EXEC -> IDLE. EXEC counter cnt counts down to 0.
//   - IDLE, edge with req!=0: winner = first set req at/after ptr, scanning ptr, ptr+1 .. mod 4.
//     Latch winner's op/a/b into alu_control/alu_x/alu_z; gnt<=onehot(winner); ptr<=winner+1 mod 4.
//     cnt<=MUL_CYCLES-1 for mul, else 0; go EXEC.
//   - gnt high exactly the first EXEC cycle, else 0.
//     Requester drops req at the edge where it samples gnt=1.
//   - EXEC: alu_control/alu_x/alu_z held stable (multicycle path for mul).
//     cnt>0: decrement. cnt==0: res_data<=alu_y (0 if op 3), res_err<=(op==3), res_id<=winner,
//     res_valid<=1, go IDLE.
//   - res_valid/res_err pulse 1 cycle; res_data/res_id hold until next result.
//   - Latency gnt->res_valid: 1 cycle add/sub/invalid, MUL_CYCLES cycles mul.
//     Min issue period: 2 cycles add/sub, MUL_CYCLES+1 mul.
//   - Arbitration in the IDLE cycle where res_valid is high is allowed; new gnt follows next cycle.
//   - req is ignored in EXEC; op/a_in/b_in changes after grant have no effect.
//   - Arithmetic: modulo 2^W; sub wraps (3-5 -> 2^W-2); mul keeps low W bits of product.
//   - op 3: no ALU result used; alu_control still presents 3.
//   - req with no requester asserted: stay IDLE, ptr unchanged.
// STRUCTURE
//   - Shared include alu_defs.vh: OP_ADD=2'd0, OP_SUB=2'd1, OP_MUL=2'd2, OP_BAD=2'd3; state codes S_IDLE, S_EXEC.
//   - Sub-module rr_arb4: combinational rotate-priority picker (req[3:0], ptr[1:0] -> onehot, idx, any).
//   - Top holds FSM, cnt ($clog2(MUL_CYCLES+1) bits), ptr, operand and result registers.
// TESTING
//   1 Hold reset_n=0, toggle inputs -> gnt, res_*, alu_* all 0; release, idle req=0 -> no gnt.
//   2 req=0001, add a=5 b=3 -> gnt=0001 one cycle; next cycle res_valid=1, res_data=8, res_id=0, res_err=0.
//   3 req1 sub 3-5 (W=8) -> res_data=0xFE, res_id=1.
//     req2 mul 12*11 -> 0x84 exactly 3 cycles after gnt; 20*20 -> 0x90.
//   4 req=1111 held, each dropped after its gnt -> gnt order 0001,0010,0100,1000.
//     Re-raise all -> 0001 next; req=1010 with ptr=2 -> 1000 then 0010.
//   5 req3 op=3 a=7 b=9 -> res_err=1, res_data=0, res_id=3, 1 cycle after gnt.
//   6 Reset pulsed mid-mul EXEC -> no res_valid, outputs 0.
//     Then req=1111 -> gnt=0001 (ptr reset).

Source files
------------

// File: rtl/alu_rr_scheduler_pkg.sv
// Shared definitions for the round-robin ALU scheduler: ALU op codes,
// FSM state encoding, requester count and a small one-hot helper.
package alu_rr_scheduler_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_BAD = 2'd3
  } alu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } sched_state_e;

  // Decode a requester index into its one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [ID_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = {N_REQ{1'b0}};
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Bundle of client request lanes, the external ALU connection and the
// tagged result return. The scheduler uses the slave view; the client/ALU
// side (or a testbench) uses the master view.
interface alu_rr_scheduler_if
  import alu_rr_scheduler_pkg::*;
#(
  parameter int unsigned W = 8
);
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] op;
  logic [N_REQ*W-1:0] a_in;
  logic [N_REQ*W-1:0] b_in;
  logic [N_REQ-1:0]   gnt;
  logic [1:0]         alu_control;
  logic [W-1:0]       alu_x;
  logic [W-1:0]       alu_z;
  logic [W-1:0]       alu_y;
  logic               res_valid;
  logic [W-1:0]       res_data;
  logic [ID_W-1:0]    res_id;
  logic               res_err;

  modport master (
    output req, op, a_in, b_in, alu_y,
    input  gnt, alu_control, alu_x, alu_z, res_valid, res_data, res_id, res_err
  );

  modport slave (
    input  req, op, a_in, b_in, alu_y,
    output gnt, alu_control, alu_x, alu_z, res_valid, res_data, res_id, res_err
  );
endinterface

// File: rtl/alu_rr_scheduler_chk.sv
// Protocol checker for the scheduler outputs: grants are one-hot single
// pulses, results are single-cycle strobes and error results carry zero data.
module alu_rr_scheduler_chk
  import alu_rr_scheduler_pkg::*;
#(
  parameter int unsigned W = 8
)(
  input logic             clk,
  input logic             reset_n,
  input logic [N_REQ-1:0] gnt,
  input logic             res_valid,
  input logic             res_err,
  input logic [W-1:0]     res_data
);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(gnt));

  a_gnt_pulse: assert property (@(posedge clk) disable iff (!reset_n)
    (gnt != 4'b0000) |=> (gnt == 4'b0000));

  a_res_pulse: assert property (@(posedge clk) disable iff (!reset_n)
    res_valid |=> !res_valid);

  a_err_zero: assert property (@(posedge clk) disable iff (!reset_n)
    res_err |-> (res_valid && (res_data == '0)));

endmodule

// File: rtl/alu_rr_scheduler_rr_arb4.sv
// Combinational rotate-priority picker for four requesters. Scanning starts
// at ptr and wraps, so the requester at ptr has highest priority.
module rr_arb4
  import alu_rr_scheduler_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0] cand_s;

  // Pick the first asserted request at or after ptr, modulo four.
  always_comb begin
    onehot = {N_REQ{1'b0}};
    idx    = 2'd0;
    any    = 1'b0;
    cand_s = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = ptr + 2'(i);
      if (!any && req[cand_s]) begin
        any    = 1'b1;
        idx    = cand_s;
        onehot = idx_to_onehot(cand_s);
      end else begin
        any    = any;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external combinational ALU between four requesters.
// A round-robin pick in IDLE captures the winner's op and operands, which
// stay stable on the ALU inputs for the whole EXEC phase (multicycle path
// for multiply). The result is returned with the requester id.
module alu_rr_scheduler
  import alu_rr_scheduler_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned MUL_CYCLES = 3
)(
  input logic               clk,
  input logic               reset_n,
  alu_rr_scheduler_if.slave bus
);

  localparam int unsigned    CNT_W   = (MUL_CYCLES < 1) ? 1 : $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MUL = (MUL_CYCLES < 1) ? CNT_W'(0) : CNT_W'(MUL_CYCLES - 1);

  sched_state_e     state_r;
  sched_state_e     state_nxt_s;
  logic [ID_W-1:0]  ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [N_REQ-1:0] gnt_r;
  logic [1:0]       alu_control_r;
  logic [W-1:0]     alu_x_r;
  logic [W-1:0]     alu_z_r;
  logic [ID_W-1:0]  winner_r;
  logic             res_valid_r;
  logic             res_err_r;
  logic [W-1:0]     res_data_r;
  logic [ID_W-1:0]  res_id_r;

  logic [N_REQ-1:0] arb_onehot_s;
  logic [ID_W-1:0]  arb_idx_s;
  logic             arb_any_s;
  logic [1:0]       op_sel_s;
  logic [W-1:0]     a_sel_s;
  logic [W-1:0]     b_sel_s;
  logic [W-1:0]     res_next_s;

  rr_arb4 u_arb (
    .req    (bus.req),
    .ptr    (ptr_r),
    .onehot (arb_onehot_s),
    .idx    (arb_idx_s),
    .any    (arb_any_s)
  );

  // Route the arbitration winner's op and operands toward the capture registers.
  always_comb begin
    op_sel_s = 2'd0;
    a_sel_s  = '0;
    b_sel_s  = '0;
    case (arb_idx_s)
      2'd0: begin
        op_sel_s = bus.op[1:0];
        a_sel_s  = bus.a_in[0*W +: W];
        b_sel_s  = bus.b_in[0*W +: W];
      end
      2'd1: begin
        op_sel_s = bus.op[3:2];
        a_sel_s  = bus.a_in[1*W +: W];
        b_sel_s  = bus.b_in[1*W +: W];
      end
      2'd2: begin
        op_sel_s = bus.op[5:4];
        a_sel_s  = bus.a_in[2*W +: W];
        b_sel_s  = bus.b_in[2*W +: W];
      end
      2'd3: begin
        op_sel_s = bus.op[7:6];
        a_sel_s  = bus.a_in[3*W +: W];
        b_sel_s  = bus.b_in[3*W +: W];
      end
      default: begin
        op_sel_s = 2'd0;
        a_sel_s  = '0;
        b_sel_s  = '0;
      end
    endcase
  end

  // Invalid ops never forward the ALU output; they return zero.
  always_comb begin
    res_next_s = '0;
    if (alu_control_r == OP_BAD) begin
      res_next_s = '0;
    end else begin
      res_next_s = bus.alu_y;
    end
  end

  // Next-state logic: leave IDLE on any request, leave EXEC when the countdown ends.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (arb_any_s) begin
          state_nxt_s = S_EXEC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt_r == '0) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_EXEC;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: capture on grant, count down in EXEC, register the tagged result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r         <= 2'd0;
      cnt_r         <= '0;
      gnt_r         <= 4'b0000;
      alu_control_r <= 2'd0;
      alu_x_r       <= '0;
      alu_z_r       <= '0;
      winner_r      <= 2'd0;
      res_valid_r   <= 1'b0;
      res_err_r     <= 1'b0;
      res_data_r    <= '0;
      res_id_r      <= 2'd0;
    end else begin
      gnt_r       <= 4'b0000;
      res_valid_r <= 1'b0;
      res_err_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (arb_any_s) begin
            alu_control_r <= op_sel_s;
            alu_x_r       <= a_sel_s;
            alu_z_r       <= b_sel_s;
            gnt_r         <= arb_onehot_s;
            winner_r      <= arb_idx_s;
            ptr_r         <= arb_idx_s + 2'd1;
            cnt_r         <= (op_sel_s == OP_MUL) ? CNT_MUL : CNT_W'(0);
          end else begin
            ptr_r <= ptr_r;
          end
        end
        S_EXEC: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else begin
            res_data_r  <= res_next_s;
            res_err_r   <= (alu_control_r == OP_BAD);
            res_id_r    <= winner_r;
            res_valid_r <= 1'b1;
          end
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_r;
  assign bus.alu_control = alu_control_r;
  assign bus.alu_x       = alu_x_r;
  assign bus.alu_z       = alu_z_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_data    = res_data_r;
  assign bus.res_id      = res_id_r;
  assign bus.res_err     = res_err_r;

  alu_rr_scheduler_chk #(.W(W)) u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .gnt       (gnt_r),
    .res_valid (res_valid_r),
    .res_err   (res_err_r),
    .res_data  (res_data_r)
  );

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler (W=8, MUL_CYCLES=3): reset behaviour,
// a table of single transactions with hand-computed results, round-robin
// ordering sequences and a reset in the middle of a multiply.
module tb_alu_rr_scheduler;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  alu_rr_scheduler_if #(.W(8)) bus ();

  alu_rr_scheduler #(.W(8), .MUL_CYCLES(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External ALU model; op 3 yields junk that must never reach res_data.
  always_comb begin
    bus.alu_y = 8'hEE;
    case (bus.alu_control)
      2'd0:    bus.alu_y = bus.alu_x + bus.alu_z;
      2'd1:    bus.alu_y = bus.alu_x - bus.alu_z;
      2'd2:    bus.alu_y = 8'(bus.alu_x * bus.alu_z);
      default: bus.alu_y = 8'hEE;
    endcase
  end

  typedef struct {
    logic [3:0] req;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] gnt;
    logic [7:0] data;
    logic [1:0] id;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a grant pulse; returns the grant vector and cycles waited.
  task automatic wait_gnt(output logic [3:0] g, output int cyc);
    g   = 4'b0000;
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0000) begin
        g   = bus.gnt;
        cyc = k;
        break;
      end
    end
    if (g == 4'b0000) check("gnt_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.gnt, bus.res_valid, bus.res_err, bus.res_id, bus.res_data,
                bus.alu_control, bus.alu_x, bus.alu_z});
  endfunction

  initial begin
    logic [3:0] g;
    int         cyc;
    int         lat;
    logic [7:0] held;
    logic       seen;
    logic [3:0] rr_exp[4];

    n_checks = 0;
    n_fail   = 0;

    //           req      op     a      b      gnt      data   id     err   lat
    vecs[0] = '{4'b0001, 2'd0, 8'd5,   8'd3,   4'b0001, 8'h08, 2'd0, 1'b0, 1};
    vecs[1] = '{4'b0010, 2'd1, 8'd3,   8'd5,   4'b0010, 8'hFE, 2'd1, 1'b0, 1};
    vecs[2] = '{4'b0100, 2'd2, 8'd12,  8'd11,  4'b0100, 8'h84, 2'd2, 1'b0, 3};
    vecs[3] = '{4'b0100, 2'd2, 8'd20,  8'd20,  4'b0100, 8'h90, 2'd2, 1'b0, 3};
    vecs[4] = '{4'b1000, 2'd3, 8'd7,   8'd9,   4'b1000, 8'h00, 2'd3, 1'b1, 1};
    vecs[5] = '{4'b0001, 2'd0, 8'd200, 8'd100, 4'b0001, 8'h2C, 2'd0, 1'b0, 1};
    vecs[6] = '{4'b0010, 2'd2, 8'd255, 8'd255, 4'b0010, 8'h01, 2'd1, 1'b0, 3};
    vecs[7] = '{4'b1000, 2'd1, 8'd0,   8'd1,   4'b1000, 8'hFF, 2'd3, 1'b0, 1};

    // Reset held: outputs stay zero while inputs toggle.
    reset_n  = 1'b0;
    bus.req  = 4'b0000;
    bus.op   = 8'h00;
    bus.a_in = 32'h0;
    bus.b_in = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req  = 4'($urandom);
      bus.op   = 8'($urandom);
      bus.a_in = 32'($urandom);
      bus.b_in = 32'($urandom);
      #1;
      check("reset_outputs", all_outs(), 64'd0);
    end
    @(negedge clk);
    bus.req = 4'b0000;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_gnt", 64'(bus.gnt), 64'd0);
    end

    // Single transactions from the table.
    for (int v = 0; v < 8; v++) begin
      bus.op   = 8'h55;
      bus.a_in = 32'hA5A5A5A5;
      bus.b_in = 32'hA5A5A5A5;
      bus.op[2*vecs[v].id +: 2]   = vecs[v].op;
      bus.a_in[8*vecs[v].id +: 8] = vecs[v].a;
      bus.b_in[8*vecs[v].id +: 8] = vecs[v].b;
      bus.req = vecs[v].req;
      wait_gnt(g, cyc);
      check("vec_gnt", 64'(g), 64'(vecs[v].gnt));
      check("vec_gnt_delay", 64'(cyc), 64'd1);
      check("vec_alu_control", 64'(bus.alu_control), 64'(vecs[v].op));
      bus.req  = bus.req & ~g;
      bus.op   = 8'($urandom);
      bus.a_in = 32'($urandom);
      bus.b_in = 32'($urandom);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (k == 1) check("gnt_pulse", 64'(bus.gnt), 64'd0);
        if (bus.res_valid) begin
          lat = k;
          break;
        end
      end
      check("vec_latency", 64'(lat), 64'(vecs[v].lat));
      check("vec_res_data", 64'(bus.res_data), 64'(vecs[v].data));
      check("vec_res_id", 64'(bus.res_id), 64'(vecs[v].id));
      check("vec_res_err", 64'(bus.res_err), 64'(vecs[v].err));
      held = bus.res_data;
      @(negedge clk);
      check("res_pulse", 64'({bus.res_valid, bus.res_err}), 64'd0);
      check("res_hold", 64'({bus.res_id, bus.res_data}), 64'({vecs[v].id, held}));
    end

    // Round robin with all requesters held (pointer is at 0 here).
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    bus.op  = 8'h00;
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g, cyc);
      check("rr_order", 64'(g), 64'(rr_exp[i]));
      bus.req = bus.req & ~g;
    end
    repeat (3) @(negedge clk);
    bus.req = 4'b1111;
    wait_gnt(g, cyc);
    check("rr_reraise_first", 64'(g), 64'(4'b0001));
    bus.req = bus.req & ~g;
    wait_gnt(g, cyc);
    check("rr_reraise_second", 64'(g), 64'(4'b0010));
    bus.req = 4'b1010;
    wait_gnt(g, cyc);
    check("rr_ptr2_first", 64'(g), 64'(4'b1000));
    bus.req = bus.req & ~g;
    wait_gnt(g, cyc);
    check("rr_ptr2_second", 64'(g), 64'(4'b0010));
    bus.req = bus.req & ~g;
    repeat (3) @(negedge clk);

    // Reset in the middle of a multiply.
    bus.op  = 8'b00_10_00_00;
    bus.a_in = 32'h00_0C_00_00;
    bus.b_in = 32'h00_0B_00_00;
    bus.req = 4'b0100;
    wait_gnt(g, cyc);
    check("mul_abort_gnt", 64'(g), 64'(4'b0100));
    bus.req = 4'b0000;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_reset_outputs", all_outs(), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    check("no_res_after_reset", 64'(seen), 64'd0);
    bus.op  = 8'h00;
    bus.req = 4'b1111;
    wait_gnt(g, cyc);
    check("ptr_after_reset", 64'(g), 64'(4'b0001));
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
